mon_capture_seq: RTL and testbench
==================================

Name: mon_capture_seq

Overview:
- Sequencer for the rf_controller monitor stream (mon_result / mon_strobe / mon_boundary).
- On a selected trigger it captures whole, boundary-aligned frames of monitor words into a local buffer, then holds until software re-arms.
- Buffer is readable over a simple synchronous read port.
- Sits between rf_controller and the local-bus readback decode.

Parameters:
- aw, 10, buffer address width; depth = 2**aw words
- dw, 20, monitor word width, matches mon_result

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  single-cycle arm request
- abort  in  1  single-cycle abort request
- trig_sel  in  1  trigger source: 0 = trig_sw, 1 = trig_ext
- trig_sw  in  1  software trigger pulse
- trig_ext  in  1  external trigger (ext_trig), level; rising edge detected internally
- n_frames  in  aw  frames to capture; 0 = capture until buffer full
- mon_result  in  dw  monitor word
- mon_strobe  in  1  mon_result valid
- mon_boundary  in  1  frame end marker
- busy  out  1  state is ARMED or CAPTURE
- done  out  1  state is DONE
- truncated  out  1  buffer filled before n_frames reached
- wr_count  out  aw+1  words written this acquisition
- frame_cnt  out  aw  boundaries seen in CAPTURE
- state  out  2  current state code
- rd_addr  in  aw  read address
- rd_data  out  dw  buffer word, one-cycle latency

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy, done, truncated = 0; wr_count, frame_cnt = 0; trig_ext edge register = 0. Buffer contents are not cleared.
- States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE or DONE, arm=1 -> ARMED. Same edge clears wr_count, frame_cnt and truncated. busy goes high the cycle after arm.
- arm is ignored in ARMED and CAPTURE.
- ARMED: wait for the selected trigger.
  - Trigger in the same cycle as arm is ignored; the trigger must arrive while in ARMED.
  - After the trigger, wait for the next mon_boundary, then -> CAPTURE.
  - If trigger and mon_boundary coincide, that boundary is the alignment boundary.
  - Strobes before and at the alignment boundary are not written.
- Frame rule: a strobe in the same cycle as mon_boundary belongs to the frame that boundary closes.
- CAPTURE write path:
  - Each mon_strobe writes mon_result at address wr_count[aw-1:0], then wr_count increments.
  - Write is registered: strobe at cycle n lands in RAM at edge n+1.
  - When wr_count == 2**aw, further strobes are dropped and truncated is set. truncated is set only if a strobe is dropped.
- CAPTURE frame counting:
  - Each mon_boundary increments frame_cnt, after any coincident strobe is written.
  - Exit to DONE on the boundary where frame_cnt+1 == n_frames (n_frames != 0).
  - Otherwise exit to DONE on the first boundary with wr_count == 2**aw (counting a coincident write).
- DONE: stays until arm or abort. Outputs stay frozen for readout.
- abort in any state -> IDLE next edge. wr_count and frame_cnt are kept; done=0. abort wins over arm in the same cycle.
- Trigger edges outside ARMED are ignored; they are not queued.
- rd_data is valid one cycle after rd_addr. Reads are allowed in any state.
  - Read/write collision at the same address returns the old data.
- n_frames change during CAPTURE takes effect at the next boundary compare.

Decomposition:
- Shared package holds:
  - state codes IDLE/ARMED/CAPTURE/DONE
  - trig_sel encodings
  - default aw and dw
- Single sub-module: dpram (existing codebase block). One write port on clk, one registered read port.
- Sequencer FSM, counters and trigger edge detection stay in the top module.

Test Plan:
- 8 strobes per frame with a boundary on the 8th; n_frames=4; trig_sw pulse mid-frame -> capture starts after the next boundary. Then wr_count=32, frame_cnt=4, done=1, truncated=0, and rd_data[0..31] equals the 32 words following the alignment boundary.
- aw=5, n_frames=0, 8 strobes per frame -> DONE on the 4th boundary, wr_count=32, truncated=0.
- aw=5, n_frames=0, 6 strobes per frame -> 32 words written at the 2nd strobe of frame 6. Remaining 4 strobes dropped, truncated=1, DONE on the 6th boundary.
- trig_sel=1; trig_ext held high before arm, then released and raised again while in ARMED -> only the second rising edge triggers. arm and trig_sw in the same cycle -> no trigger.
- Mid-CAPTURE abort -> IDLE next cycle, busy=0, wr_count kept. Re-arm -> wr_count=0, and a new acquisition completes correctly.
- rst_n low mid-CAPTURE for 1 cycle, asynchronous to clk -> all outputs return to reset values immediately; no RAM writes while reset is asserted.

Source files
------------

// File: rtl/mon_capture_seq_pkg.sv
// Shared definitions for the monitor capture sequencer: state codes,
// trigger-source encodings, default geometry and the trigger-select helper.
package mon_capture_seq_pkg;

    localparam int unsigned AW_DEFAULT = 10;
    localparam int unsigned DW_DEFAULT = 20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic {
        TRIG_SW  = 1'b0,
        TRIG_EXT = 1'b1
    } trig_sel_e;

    // Pick the active trigger event for this cycle from the selected source.
    function automatic logic select_trigger(input logic sel, input logic sw_pulse,
                                            input logic ext_rise);
        return (trig_sel_e'(sel) == TRIG_EXT) ? ext_rise : sw_pulse;
    endfunction

endpackage

// File: rtl/mon_capture_seq_if.sv
// Monitor stream from rf_controller: one word per strobe, boundary marks frame end.
interface mon_capture_seq_if #(
    parameter int unsigned dw = mon_capture_seq_pkg::DW_DEFAULT
);
    logic [dw-1:0] mon_result;
    logic          mon_strobe;
    logic          mon_boundary;

    // Producer side (rf_controller, or a bench standing in for it).
    modport master (
        output mon_result,
        output mon_strobe,
        output mon_boundary
    );

    // Consumer side (capture sequencer).
    modport slave (
        input mon_result,
        input mon_strobe,
        input mon_boundary
    );
endinterface

// File: rtl/mon_capture_seq_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port,
// both on clk. A read and write to the same address in one cycle returns the
// previous contents.
module mon_capture_seq_dpram #(
    parameter int unsigned aw = 10,
    parameter int unsigned dw = 20
) (
    input  logic          clk,
    input  logic          we,
    input  logic [aw-1:0] wa,
    input  logic [dw-1:0] wd,
    input  logic [aw-1:0] ra,
    output logic [dw-1:0] rd
);

    logic [dw-1:0] mem [2**aw];

    // Write port and registered read port.
    // NOTE: the array has no reset so it maps onto block RAM; the sequencer
    // keeps we low while rst_n is asserted. Both assignments are non-blocking,
    // so a same-address read in the write cycle sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        rd <= mem[ra];
    end

endmodule

// File: rtl/mon_capture_seq.sv
// Monitor capture sequencer: arms on request, waits for the selected trigger,
// aligns to the next frame boundary, then captures whole frames of monitor
// words into a local buffer until n_frames are in or the buffer fills.
// The buffer is read back through a one-cycle-latency read port.
module mon_capture_seq
    import mon_capture_seq_pkg::*;
#(
    parameter int unsigned aw = AW_DEFAULT,
    parameter int unsigned dw = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trig_sel,
    input  logic                 trig_sw,
    input  logic                 trig_ext,
    input  logic [aw-1:0]        n_frames,
    mon_capture_seq_if.slave     mon,
    output logic                 busy,
    output logic                 done,
    output logic                 truncated,
    output logic [aw:0]          wr_count,
    output logic [aw-1:0]        frame_cnt,
    output logic [1:0]           state,
    input  logic [aw-1:0]        rd_addr,
    output logic [dw-1:0]        rd_data
);

    // Word count at which the buffer is full (2**aw).
    localparam logic [aw:0] DEPTH = {1'b1, {aw{1'b0}}};

    state_e          state_q,     state_d;
    logic [aw:0]     wr_count_q,  wr_count_d;
    logic [aw-1:0]   frame_cnt_q, frame_cnt_d;
    logic            truncated_q, truncated_d;
    logic            trig_seen_q, trig_seen_d;
    logic            trig_ext_q,  trig_ext_d;

    logic            ext_rise;
    logic            trig_fire;
    logic            buf_full;
    logic            frame_hit;
    logic            capture_exit;
    logic            wr_en;
    logic [aw-1:0]   wr_addr;

    // ------------------------------------------------------------------
    // Trigger detection
    // ------------------------------------------------------------------
    assign trig_ext_d = trig_ext;
    assign ext_rise   = trig_ext & ~trig_ext_q;
    assign trig_fire  = select_trigger(trig_sel, trig_sw, ext_rise);

    // Buffer full before this cycle's write, and n_frames reached at this boundary.
    assign buf_full  = (wr_count_q == DEPTH);
    assign frame_hit = (n_frames != '0) && ((frame_cnt_q + aw'(1)) == n_frames);

    // ------------------------------------------------------------------
    // State register and datapath registers.
    // ------------------------------------------------------------------
    // Hold FSM state, counters and the trigger edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_count_q  <= '0;
            frame_cnt_q <= '0;
            truncated_q <= 1'b0;
            trig_seen_q <= 1'b0;
            trig_ext_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            frame_cnt_q <= frame_cnt_d;
            truncated_q <= truncated_d;
            trig_seen_q <= trig_seen_d;
            trig_ext_q  <= trig_ext_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. abort overrides everything, including arm.
    // ------------------------------------------------------------------
    // Sequence IDLE/DONE -> ARMED -> CAPTURE -> DONE.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    // A trigger coinciding with a boundary makes that boundary the alignment point.
                    if ((trig_seen_q || trig_fire) && mon.mon_boundary) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (capture_exit) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters, write strobe and capture exit condition.
    // ------------------------------------------------------------------
    // Compute next counter values, the buffer write and the end-of-capture decision.
    // NOTE: every output of this block is given a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_count_d   = wr_count_q;
        frame_cnt_d  = frame_cnt_q;
        truncated_d  = truncated_q;
        trig_seen_d  = trig_seen_q;
        wr_en        = 1'b0;
        wr_addr      = wr_count_q[aw-1:0];
        capture_exit = 1'b0;

        if (!abort) begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        wr_count_d  = '0;
                        frame_cnt_d = '0;
                        truncated_d = 1'b0;
                        trig_seen_d = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (trig_fire) trig_seen_d = 1'b1;
                end
                ST_CAPTURE: begin
                    // A strobe on the boundary cycle still belongs to the closing frame.
                    if (mon.mon_strobe) begin
                        if (buf_full) begin
                            truncated_d = 1'b1;
                        end else begin
                            wr_en      = 1'b1;
                            wr_count_d = wr_count_q + (aw+1)'(1);
                        end
                    end
                    if (mon.mon_boundary) begin
                        frame_cnt_d  = frame_cnt_q + aw'(1);
                        capture_exit = frame_hit || (wr_count_d == DEPTH);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status outputs, all derived from registered state.
    // ------------------------------------------------------------------
    // Decode status flags from the current state and counters.
    always_comb begin
        busy      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
        done      = (state_q == ST_DONE);
        state     = state_q;
        truncated = truncated_q;
        wr_count  = wr_count_q;
        frame_cnt = frame_cnt_q;
    end

    // ------------------------------------------------------------------
    // Capture buffer.
    // ------------------------------------------------------------------
    mon_capture_seq_dpram #(
        .aw (aw),
        .dw (dw)
    ) u_buf (
        .clk (clk),
        .we  (wr_en),
        .wa  (wr_addr),
        .wd  (mon.mon_result),
        .ra  (rd_addr),
        .rd  (rd_data)
    );

endmodule

// File: tb/tb_mon_capture_seq.sv
// Scoreboard bench for mon_capture_seq with a 32-word buffer (aw=5).
// Each captured strobe pushes {address, word} when driven; buffer readout
// pops and compares. A shadow image of the buffer checks read/write
// collisions and that reset neither writes nor clears the RAM.
module tb_mon_capture_seq;
    import mon_capture_seq_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 20;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm, abort, trig_sel, trig_sw, trig_ext;
    logic [AW-1:0] n_frames;
    logic          busy, done, truncated;
    logic [AW:0]   wr_count;
    logic [AW-1:0] frame_cnt;
    logic [1:0]    state;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    mon_capture_seq_if #(.dw(DW)) mon_if ();

    mon_capture_seq #(.aw(AW), .dw(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .abort     (abort),
        .trig_sel  (trig_sel),
        .trig_sw   (trig_sw),
        .trig_ext  (trig_ext),
        .n_frames  (n_frames),
        .mon       (mon_if.slave),
        .busy      (busy),
        .done      (done),
        .truncated (truncated),
        .wr_count  (wr_count),
        .frame_cnt (frame_cnt),
        .state     (state),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] shadow    [DEPTH];
    bit            shadow_ok [DEPTH];
    int            cap_cnt   = 0;
    logic [DW-1:0] next_word = 20'h1_0000;
    bit            collide_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input int st, input bit bz, input bit dn,
                          input bit tr, input int wc, input int fc);
        check({tag, ".state"},     32'(state),     32'(st));
        check({tag, ".busy"},      32'(busy),      32'(bz));
        check({tag, ".done"},      32'(done),      32'(dn));
        check({tag, ".truncated"}, 32'(truncated), 32'(tr));
        check({tag, ".wr_count"},  32'(wr_count),  32'(wc));
        check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(fc));
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cap_cnt = 0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // One frame of spf strobes. sw_at / ext_at: strobe index at which to pulse
    // trig_sw / raise trig_ext (-1 = never). cap: bench expects these captured.
    task automatic send_frame(input int spf, input int sw_at, input int ext_at,
                              input bit cap, input bit bnd, input bit gaps);
        for (int i = 0; i < spf; i++) begin
            logic [DW-1:0] w;
            logic [DW-1:0] old;
            int            addr;
            bit            do_wr;
            bit            chk_old;
            w = next_word;
            next_word = next_word + 20'd1;
            mon_if.mon_strobe   = 1'b1;
            mon_if.mon_result   = w;
            mon_if.mon_boundary = bnd && (i == spf - 1);
            if (i == sw_at)  trig_sw  = 1'b1;
            if (i == ext_at) trig_ext = 1'b1;
            do_wr   = cap && (cap_cnt < DEPTH);
            addr    = cap_cnt;
            chk_old = 1'b0;
            old     = '0;
            if (do_wr && collide_en && shadow_ok[addr]) begin
                rd_addr = AW'(addr);
                old     = shadow[addr];
                chk_old = 1'b1;
            end
            tick();
            if (chk_old) check("collide_old", 32'(rd_data), 32'(old));
            if (do_wr) begin
                shadow[addr]    = w;
                shadow_ok[addr] = 1'b1;
                exp_q.push_back('{AW'(addr), w});
            end
            if (cap) cap_cnt++;
            mon_if.mon_strobe   = 1'b0;
            mon_if.mon_boundary = 1'b0;
            trig_sw             = 1'b0;
            if (gaps && (i % 3 == 1)) tick();
        end
    endtask

    task automatic readout(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_addr = e.addr;
            tick();
            check(tag, 32'(rd_data), 32'(e.data));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) shadow_ok[i] = 1'b0;
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig_sel = 1'b0;
        trig_sw = 1'b0; trig_ext = 1'b0; n_frames = '0; rd_addr = '0;
        mon_if.mon_strobe = 1'b0; mon_if.mon_boundary = 1'b0; mon_if.mon_result = '0;
        tick(); tick();
        chk_st("reset", 0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b1;
        tick();

        // Test 1: n_frames=4, 8 strobes/frame, trig_sw mid-frame.
        n_frames = 5'd4;
        do_arm();
        chk_st("t1_armed", 1, 1, 0, 0, 0, 0);
        send_frame(8, 3, -1, 1'b0, 1'b1, 1'b0);
        check("t1_aligned.state", 32'(state), 32'(ST_CAPTURE));
        for (int f = 0; f < 4; f++) send_frame(8, -1, -1, 1'b1, 1'b1, 1'b0);
        chk_st("t1_done", 3, 0, 1, 0, 32, 4);
        readout("t1_data");

        // Test 1b: re-arm from DONE, n_frames=2, trigger on the boundary cycle, gapped strobes.
        n_frames = 5'd2;
        do_arm();
        chk_st("t1b_armed", 1, 1, 0, 0, 0, 0);
        send_frame(8, 7, -1, 1'b0, 1'b1, 1'b1);
        check("t1b_aligned.state", 32'(state), 32'(ST_CAPTURE));
        send_frame(8, -1, -1, 1'b1, 1'b1, 1'b1);
        send_frame(8, -1, -1, 1'b1, 1'b1, 1'b1);
        chk_st("t1b_done", 3, 0, 1, 0, 16, 2);
        readout("t1b_data");

        // Test 2: n_frames=0, 8 strobes/frame -> DONE on 4th boundary (full); collision reads.
        n_frames = 5'd0;
        collide_en = 1'b1;
        do_arm();
        send_frame(8, 2, -1, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(8, -1, -1, 1'b1, 1'b1, 1'b0);
        chk_st("t2_mid", 2, 1, 0, 0, 24, 3);
        send_frame(8, -1, -1, 1'b1, 1'b1, 1'b0);
        chk_st("t2_done", 3, 0, 1, 0, 32, 4);
        collide_en = 1'b0;
        readout("t2_data");

        // Test 3: n_frames=0, 6 strobes/frame -> truncation in frame 6.
        do_arm();
        send_frame(6, 1, -1, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 5; f++) send_frame(6, -1, -1, 1'b1, 1'b1, 1'b0);
        chk_st("t3_f5", 2, 1, 0, 0, 30, 5);
        send_frame(3, -1, -1, 1'b1, 1'b0, 1'b0);
        chk_st("t3_drop", 2, 1, 0, 1, 32, 5);
        send_frame(3, -1, -1, 1'b1, 1'b1, 1'b0);
        chk_st("t3_done", 3, 0, 1, 1, 32, 6);
        readout("t3_data");

        // Test 4a: trig_sw in IDLE is not queued; trig_sw with arm is ignored.
        n_frames = 5'd1;
        do_abort();
        trig_sw = 1'b1; tick(); trig_sw = 1'b0;
        arm = 1'b1; trig_sw = 1'b1; tick(); arm = 1'b0; trig_sw = 1'b0;
        send_frame(8, -1, -1, 1'b0, 1'b1, 1'b0);
        check("t4a_still_armed", 32'(state), 32'(ST_ARMED));
        do_abort();
        chk_st("t4a_abort", 0, 0, 0, 0, 0, 0);

        // Test 4b: trig_ext held high before arm; only the later rising edge triggers.
        trig_sel = 1'b1;
        trig_ext = 1'b1;
        tick(); tick();
        do_arm();
        send_frame(8, -1, -1, 1'b0, 1'b1, 1'b0);
        check("t4b_level_ignored", 32'(state), 32'(ST_ARMED));
        trig_ext = 1'b0;
        tick();
        send_frame(8, -1, 4, 1'b0, 1'b1, 1'b0);
        check("t4b_aligned.state", 32'(state), 32'(ST_CAPTURE));
        send_frame(8, -1, -1, 1'b1, 1'b1, 1'b0);
        chk_st("t4b_done", 3, 0, 1, 0, 8, 1);
        readout("t4b_data");
        trig_ext = 1'b0;
        trig_sel = 1'b0;

        // Test 5: abort mid-CAPTURE keeps counters; re-arm clears and recaptures.
        n_frames = 5'd0;
        do_arm();
        send_frame(8, 2, -1, 1'b0, 1'b1, 1'b0);
        send_frame(8, -1, -1, 1'b1, 1'b1, 1'b0);
        send_frame(5, -1, -1, 1'b1, 1'b0, 1'b0);
        do_abort();
        chk_st("t5_abort", 0, 0, 0, 0, 13, 1);
        readout("t5_partial");
        n_frames = 5'd2;
        do_arm();
        chk_st("t5_rearm", 1, 1, 0, 0, 0, 0);
        send_frame(8, 4, -1, 1'b0, 1'b1, 1'b0);
        send_frame(8, -1, -1, 1'b1, 1'b1, 1'b0);
        send_frame(8, -1, -1, 1'b1, 1'b1, 1'b0);
        chk_st("t5_done", 3, 0, 1, 0, 16, 2);
        readout("t5_data");

        // Test 6: asynchronous reset pulse mid-CAPTURE.
        n_frames = 5'd0;
        do_arm();
        send_frame(8, 1, -1, 1'b0, 1'b1, 1'b0);
        send_frame(3, -1, -1, 1'b1, 1'b0, 1'b0);
        mon_if.mon_strobe = 1'b1;
        mon_if.mon_result = 20'hBAD00;
        #3 rst_n = 1'b0;
        #1;
        chk_st("t6_async", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        mon_if.mon_result = 20'hBAD01;
        check("t6_in_reset.state", 32'(state), 32'(ST_IDLE));
        #3 rst_n = 1'b1;
        mon_if.mon_strobe = 1'b0;
        tick();
        chk_st("t6_after", 0, 0, 0, 0, 0, 0);
        readout("t6_pre_reset");
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            tick();
            check("t6_ram_intact", 32'(rd_data), 32'(shadow[a]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
